// File: rtl/master_port.sv
// rtl/master_port.sv - serial bus initiator: parallel core requests to serial address/data, serial read data back.
// Optional read-wait timeout is enabled with `define MASTER_PORT_TIMEOUT_EN.
module master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  m_valid,
    output logic                  write_enable,
    output logic                  read_enable,
    output logic                  tx_address,
    output logic                  tx_data,
    output logic                  m_ready,
    input  logic                  s_ready,
    input  logic                  s_valid,
    input  logic                  rx_data
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_RWAIT, S_RESP} state_t;

    localparam int CW = $clog2(ADDR_WIDTH + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_bit_cnt;
    logic [ADDR_WIDTH-1:0] r_addr_sh;
    logic [DATA_WIDTH-1:0] r_wdata_sh;
    logic [DATA_WIDTH-1:0] r_rdata_sh;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic [DATA_WIDTH-1:0] w_rdata_shifted;
    logic                  r_write;
    logic                  w_accept;
    logic                  w_capture;
    logic                  w_timeout;

    logic r_m_valid, r_m_ready, r_rsp_valid, r_write_enable, r_read_enable;
    logic w_m_valid_nxt, w_m_ready_nxt, w_rsp_valid_nxt, w_write_enable_nxt, w_read_enable_nxt;

    assign req_ready       = reset && (r_state == S_IDLE) && s_ready;
    assign w_accept        = (r_state == S_IDLE) && req_valid && s_ready;
    assign w_capture       = (r_state == S_RWAIT) && s_valid;
    assign w_rdata_shifted = {r_rdata_sh[DATA_WIDTH-2:0], rx_data};

`ifdef MASTER_PORT_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] r_wait_cnt;
    logic          r_rsp_error;

    assign w_timeout = (r_state == S_RWAIT) && !s_valid && (r_wait_cnt == WAIT_LAST);
    assign rsp_error = r_rsp_error;

    // Counts consecutive idle RWAIT cycles; any captured bit restarts the window.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wait_cnt  <= '0;
            r_rsp_error <= 1'b0;
        end else begin
            r_rsp_error <= w_timeout;
            if (r_state != S_RWAIT || s_valid)
                r_wait_cnt <= '0;
            else
                r_wait_cnt <= r_wait_cnt + TW'(1);
        end
    end
`else
    assign w_timeout = 1'b0;
    assign rsp_error = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_ADDR;
            S_ADDR:  if (r_bit_cnt == ADDR_LAST) w_state_nxt = r_write ? S_RESP : S_RWAIT;
            S_RWAIT: if ((w_capture && r_bit_cnt == DATA_LAST) || w_timeout) w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs are decoded from the next state so they appear registered in the cycle the state is entered.
    always_comb begin
        w_m_valid_nxt      = (w_state_nxt == S_ADDR);
        w_m_ready_nxt      = (w_state_nxt == S_RWAIT);
        w_rsp_valid_nxt    = (w_state_nxt == S_RESP);
        w_write_enable_nxt = w_accept && req_write;
        w_read_enable_nxt  = w_accept && !req_write;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_m_valid      <= 1'b0;
            r_m_ready      <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_write_enable <= 1'b0;
            r_read_enable  <= 1'b0;
        end else begin
            r_m_valid      <= w_m_valid_nxt;
            r_m_ready      <= w_m_ready_nxt;
            r_rsp_valid    <= w_rsp_valid_nxt;
            r_write_enable <= w_write_enable_nxt;
            r_read_enable  <= w_read_enable_nxt;
        end
    end

    // Shifters fill with zeros, so both serial lines fall to 0 once their bits are out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bit_cnt   <= '0;
            r_addr_sh   <= '0;
            r_wdata_sh  <= '0;
            r_rdata_sh  <= '0;
            r_rsp_rdata <= '0;
            r_write     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr_sh  <= req_addr;
                        r_wdata_sh <= req_write ? req_wdata : '0;
                        r_write    <= req_write;
                        r_bit_cnt  <= '0;
                        r_rdata_sh <= '0;
                    end
                end
                S_ADDR: begin
                    r_addr_sh  <= r_addr_sh << 1;
                    r_wdata_sh <= r_wdata_sh << 1;
                    r_bit_cnt  <= (r_bit_cnt == ADDR_LAST) ? '0 : r_bit_cnt + CW'(1);
                end
                S_RWAIT: begin
                    if (w_capture) begin
                        r_rdata_sh <= w_rdata_shifted;
                        r_bit_cnt  <= r_bit_cnt + CW'(1);
                        if (r_bit_cnt == DATA_LAST)
                            r_rsp_rdata <= w_rdata_shifted;
                    end else if (w_timeout) begin
                        r_rsp_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_valid      = r_m_valid;
    assign m_ready      = r_m_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_rdata    = r_rsp_rdata;
    assign write_enable = r_write_enable;
    assign read_enable  = r_read_enable;
    assign tx_address   = r_addr_sh[ADDR_WIDTH-1];
    assign tx_data      = r_wdata_sh[DATA_WIDTH-1];

endmodule

// File: tb/tb_master_port.sv
// tb/tb_master_port.sv - directed self-checking bench for master_port.
module tb_master_port;

    localparam int AW = 12;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_error;
    logic          m_valid;
    logic          write_enable;
    logic          read_enable;
    logic          tx_address;
    logic          tx_data;
    logic          m_ready;
    logic          s_ready = 1'b1;
    logic          s_valid = 1'b0;
    logic          rx_data = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .m_valid(m_valid), .write_enable(write_enable), .read_enable(read_enable),
        .tx_address(tx_address), .tx_data(tx_data), .m_ready(m_ready),
        .s_ready(s_ready), .s_valid(s_valid), .rx_data(rx_data)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge. exp_lat is the response cycle counted from the accept edge.
    task automatic run_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                            input logic [DW-1:0] rd, input int gap_at, input int gap_len,
                            input int exp_lat, input logic [DW-1:0] exp_rdata,
                            input logic exp_err, input int abort_k);
        logic [AW-1:0] a_sh;
        logic [DW-1:0] w_sh;
        logic [DW-1:0] r_sh;
        int            bit_n;
        int            j;
        a_sh  = addr;
        w_sh  = wr ? wd : '0;
        r_sh  = rd;
        bit_n = 0;
        s_ready   = 1'b1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        #1;
        check("req_ready_at_accept", 32'(req_ready), 32'd1);
        @(posedge clk);
        for (int k = 1; k <= exp_lat + 1; k++) begin
            @(negedge clk);
            if (k == abort_k) begin
                reset = 1'b0;
                #1;
                check("abort_m_ready", 32'(m_ready), 32'd0);
                check("abort_m_valid", 32'(m_valid), 32'd0);
                check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
                check("abort_rsp_rdata", 32'(rsp_rdata), 32'd0);
                check("abort_req_ready", 32'(req_ready), 32'd0);
                check("abort_tx_address", 32'(tx_address), 32'd0);
                s_valid = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (k <= AW) begin
                check($sformatf("m_valid k%0d", k), 32'(m_valid), 32'd1);
                check($sformatf("tx_address k%0d", k), 32'(tx_address), 32'(a_sh[AW-1]));
                check($sformatf("tx_data k%0d", k), 32'(tx_data), 32'(w_sh[DW-1]));
                check($sformatf("write_enable k%0d", k), 32'(write_enable), 32'(wr && k == 1));
                check($sformatf("read_enable k%0d", k), 32'(read_enable), 32'(!wr && k == 1));
                check($sformatf("req_ready_busy k%0d", k), 32'(req_ready), 32'd0);
                check($sformatf("m_ready_addr k%0d", k), 32'(m_ready), 32'd0);
                a_sh = a_sh << 1;
                w_sh = w_sh << 1;
            end else if (k < exp_lat) begin
                check($sformatf("m_ready_wait k%0d", k), 32'(m_ready), 32'd1);
                check($sformatf("m_valid_wait k%0d", k), 32'(m_valid), 32'd0);
                check($sformatf("rsp_valid_early k%0d", k), 32'(rsp_valid), 32'd0);
            end else if (k == exp_lat) begin
                check("rsp_valid", 32'(rsp_valid), 32'd1);
                check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
                check("rsp_error", 32'(rsp_error), 32'(exp_err));
                check("m_ready_resp", 32'(m_ready), 32'd0);
                check("m_valid_resp", 32'(m_valid), 32'd0);
            end else begin
                check("rsp_valid_after", 32'(rsp_valid), 32'd0);
                check("req_ready_after", 32'(req_ready), 32'd1);
            end
            req_valid = 1'b0;
            if (k == 2) s_ready = 1'b0;
            if (k == exp_lat) s_ready = 1'b1;
            // Slave noise during the address phase must be ignored.
            if (k <= AW) begin
                s_valid = 1'b1;
                rx_data = 1'b1;
            end else begin
                j = k - (AW + 1);
                if (!wr && bit_n < DW && !(j >= gap_at && j < gap_at + gap_len)) begin
                    s_valid = 1'b1;
                    rx_data = r_sh[DW-1];
                    r_sh    = r_sh << 1;
                    bit_n++;
                end else begin
                    s_valid = 1'b0;
                    rx_data = 1'b0;
                end
            end
        end
    endtask

    initial begin
        req_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_rsp_error", 32'(rsp_error), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_write_enable", 32'(write_enable), 32'd0);
        check("rst_read_enable", 32'(read_enable), 32'd0);
        check("rst_tx_address", 32'(tx_address), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_m_ready", 32'(m_ready), 32'd0);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("idle_req_ready", 32'(req_ready), 32'd1);

        // Write C03/9F: response 13 cycles after accept, rdata untouched.
        run_xfer(1'b1, 12'hC03, 8'h9F, 8'h00, 0, 0, 13, 8'h00, 1'b0, 0);
        // Read 080 returning A5 with no gaps: 12 address + 1 + 8 bits.
        run_xfer(1'b0, 12'h080, 8'h00, 8'hA5, 0, 0, 21, 8'hA5, 1'b0, 0);
        // Same read with a 3-cycle gap after bit 4.
        run_xfer(1'b0, 12'h080, 8'h00, 8'hA5, 4, 3, 24, 8'hA5, 1'b0, 0);

        s_ready   = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 12'h555;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("stall_req_ready %0d", i), 32'(req_ready), 32'd0);
            check($sformatf("stall_m_valid %0d", i), 32'(m_valid), 32'd0);
            check($sformatf("stall_read_enable %0d", i), 32'(read_enable), 32'd0);
        end
        run_xfer(1'b1, 12'h7FF, 8'h01, 8'h00, 0, 0, 13, 8'hA5, 1'b0, 0);

        // Reset in RWAIT after three captured bits, then a clean read of 3C.
        run_xfer(1'b0, 12'h080, 8'h00, 8'hA5, 0, 0, 21, 8'hA5, 1'b0, 16);
        run_xfer(1'b0, 12'h3C3, 8'h00, 8'h3C, 0, 0, 21, 8'h3C, 1'b0, 0);

`ifdef MASTER_PORT_TIMEOUT_EN
        // No read data ever: error response 64 cycles after m_ready rises.
        run_xfer(1'b0, 12'h0F0, 8'h00, 8'hFF, 0, 1000, 77, 8'h00, 1'b1, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/master_port.md
# master_port

Initiator end of the serial bus: accepts parallel read/write requests from the local core and serialises them onto the bus toward `slave_wrapper`, then deserialises read data returned by the slave. It owns the bus-side `m_valid`/`m_ready`, `read_enable`/`write_enable`, serial address and serial write-data lines. It returns one response per request to the core.

## Interface
- `ADDR_WIDTH`, 12, address bits serialised per transfer
- `DATA_WIDTH`, 8, data bits per transfer (must be ≤ `ADDR_WIDTH`)
- `TIMEOUT`, 64, read-wait limit in cycles (used only with `MASTER_PORT_TIMEOUT_EN`)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `reset` in 1: asynchronous, active-low reset
- `req_valid` in 1: core request present
- `req_ready` out 1: request accepted on `req_valid && req_ready`
- `req_write` in 1: 1 = write, 0 = read
- `req_addr` in `ADDR_WIDTH`: request address
- `req_wdata` in `DATA_WIDTH`: write data
- `rsp_valid` out 1: one-cycle completion pulse
- `rsp_rdata` out `DATA_WIDTH`: read data, held until next response
- `rsp_error` out 1: timeout flag, qualified by `rsp_valid`
- `m_valid` out 1: master driving address/data bits
- `write_enable` out 1: write command strobe
- `read_enable` out 1: read command strobe
- `tx_address` out 1: serial address, MSB first
- `tx_data` out 1: serial write data, MSB first
- `m_ready` out 1: master ready to take read data
- `s_ready` in 1: slave idle and able to accept a command
- `s_valid` in 1: slave driving a valid read-data bit
- `rx_data` in 1: serial read data from slave, MSB first

## Operation
- States: IDLE, ADDR, RWAIT, RESP.
- IDLE: `req_ready = s_ready`. On accept, latch addr/wdata/write into shift registers, clear bit counter, go to ADDR.
- ADDR: exactly `ADDR_WIDTH` cycles. `m_valid = 1`. `tx_address` = current address MSB, shifting left each cycle. `write_enable`/`read_enable` (per `req_write`) high in the first ADDR cycle only.
  - Write: `tx_data` carries `req_wdata` MSB first during the first `DATA_WIDTH` ADDR cycles, then 0.
  - Read: `tx_data` is 0 throughout.
- After the last address bit: write goes to RESP; read goes to RWAIT.
- RWAIT: `m_valid = 0`, `m_ready = 1`. On each edge with `s_valid = 1`, shift `rx_data` into the LSB of the read shift register and increment the bit counter. Cycles with `s_valid = 0` are gaps and capture nothing. After `DATA_WIDTH` captured bits, go to RESP.
- RESP: one cycle. `rsp_valid = 1`; `rsp_rdata` = captured data for a read, unchanged for a write. Then return to IDLE.
- `s_valid` outside RWAIT is ignored. `req_valid` outside IDLE is not accepted.
- Reset (any state, asynchronous): return to IDLE, clear all counters and shift registers.

## Timing
- Reset values: `req_ready` 0 while reset is asserted; `rsp_valid`, `rsp_rdata`, `rsp_error`, `m_valid`, `write_enable`, `read_enable`, `tx_address`, `tx_data`, `m_ready` all 0.
- All bus outputs are registered. `req_ready` is combinational from state and `s_ready`.
- Accept at edge E:
  - First address bit and strobe are visible in cycle E+1.
  - Last address bit is in cycle E+`ADDR_WIDTH`.
- Write latency: `rsp_valid` in cycle E+`ADDR_WIDTH`+1.
- Read latency: `m_ready` rises in cycle E+`ADDR_WIDTH`+1. `rsp_valid` comes one cycle after the edge that captures the final bit.
- Back-to-back: the next request can be accepted in the cycle after RESP, giving a minimum one idle cycle between transfers.
- `s_ready` falling during a transfer has no effect. It is checked only at accept.

## Configuration
- `MASTER_PORT_TIMEOUT_EN` defined:
  - A counter runs in RWAIT and clears on every captured bit.
  - If it reaches `TIMEOUT` with `s_valid` low, go to RESP with `rsp_error = 1` and `rsp_rdata = 0`.
- Not defined: RWAIT waits indefinitely, `rsp_error` is tied 0, and no counter is built.

## Test plan
- Write `req_addr = 12'hC03`, `req_wdata = 8'h9F`:
  - `tx_address` = 1100_0000_0011 over 12 cycles; `tx_data` = 1001_1111 then 0000.
  - `write_enable` high in the first cycle only; `rsp_valid` at accept+13.
- Read `req_addr = 12'h080`; slave returns 8'hA5 with `s_valid` high for 8 consecutive cycles:
  - `tx_address` = 0000_1000_0000 and `read_enable` is a one-cycle pulse.
  - `rsp_rdata = 8'hA5`, `rsp_error = 0`.
- Same read with `s_valid` dropping for 3 cycles after bit 4 → still `rsp_rdata = 8'hA5`, with `rsp_valid` 3 cycles later.
- `s_ready = 0` with `req_valid = 1` for 10 cycles → `req_ready = 0` and bus idle; raise `s_ready` → accept next edge.
- Reset asserted in RWAIT after 3 bits → all outputs 0 immediately; a following read of 8'h3C completes correctly.
- With `MASTER_PORT_TIMEOUT_EN`, `TIMEOUT = 64`, `s_valid` never asserted → `rsp_valid` with `rsp_error = 1`, `rsp_rdata = 0` exactly 64 cycles after `m_ready` rises.
